dmem_mmio: RTL and testbench

//  Memory-side responder for the pipelined core's M-stage data port: services

---
 rtl/dmem_mmio.sv | 144 ++++++++++++++
 tb/tb_dmem_mmio.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-memory responder for the core's M stage: word RAM plus an MMIO page holding
// a free-running cycle counter, a valid/ready transmit FIFO and a sticky halt flag.
module dmem_mmio #(
    parameter int          RAM_AW    = 6,
    parameter int          FIFO_AW   = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        halted
);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] PTR_ZERO   = {(FIFO_AW + 1){1'b0}};
    localparam logic [5:0]       OFF_CYCLE  = 6'h00;
    localparam logic [5:0]       OFF_TXDATA = 6'h01;
    localparam logic [5:0]       OFF_STATUS = 6'h02;
    localparam logic [5:0]       OFF_HALT   = 6'h03;

    logic [31:0]        ram_q [2**RAM_AW];
    logic [31:0]        fifo_q [DEPTH];
    logic [31:0]        cycle_q, cycle_d;
    logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_s;
    logic               ovf_q, ovf_d, halted_q, halted_d;
    logic               mmio_s, full_s, empty_s, pop_s;
    logic               push_req_s, push_s, ovf_set_s, ovf_clr_s, halt_wr_s;
    logic [5:0]         off_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic [31:0]        status_s;
    logic               unused_addr_s;

    assign mmio_s        = (addr[31:8] == MMIO_BASE[31:8]);
    assign off_s         = addr[7:2];
    assign ram_idx_s     = addr[RAM_AW+1:2];
    assign unused_addr_s = ^addr[1:0];

    assign cycle_d = cycle_q + 32'd1;
    assign count_s = wptr_q - rptr_q;
    assign full_s  = (count_s == FULL_CNT);
    assign empty_s = (count_s == PTR_ZERO);
    assign pop_s   = ~empty_s & tx_ready;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_req_s = memwrite & mmio_s & (off_s == OFF_TXDATA);
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_set_s  = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s  = memwrite & mmio_s & (off_s == OFF_STATUS) & wdata[31];
    assign halt_wr_s  = memwrite & mmio_s & (off_s == OFF_HALT);

    assign tx_valid = ~empty_s;
    assign tx_data  = fifo_q[rptr_q[FIFO_AW-1:0]];
    assign halted   = halted_q;

    // Next-state for FIFO pointers and the sticky flags; ovf set beats clear.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ovf_d    = ovf_q;
        halted_d = halted_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (halt_wr_s) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q  <= 32'd0;
            wptr_q   <= PTR_ZERO;
            rptr_q   <= PTR_ZERO;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    // Storage arrays are never reset; the pointers alone define FIFO occupancy.
    always_ff @(posedge clk) begin
        if (memwrite && !mmio_s) begin
            ram_q[ram_idx_s] <= wdata;
        end
        if (push_s) begin
            fifo_q[wptr_q[FIFO_AW-1:0]] <= wdata;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s              = 32'd0;
        status_s[FIFO_AW:0]   = count_s;
        status_s[16]          = full_s;
        status_s[17]          = empty_s;
        status_s[31]          = ovf_q;
    end

    // Load data mux.
    always_comb begin
        rdata = 32'd0;
        if (mmio_s) begin
            case (off_s)
                OFF_CYCLE:  rdata = cycle_q;
                OFF_STATUS: rdata = status_s;
                OFF_HALT:   rdata = {31'd0, halted_q};
                default:    rdata = 32'd0;
            endcase
        end else begin
            rdata = ram_q[ram_idx_s];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, cycle counter, TX FIFO, ovf and halt behaviour.
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        halted;

    int vectors = 0;
    int fails   = 0;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FF04;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
    localparam logic [31:0] A_HALT   = 32'hFFFF_FF0C;

    dmem_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge, ending on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        memwrite = 1'b0;
        addr     = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        addr     = a;
        wdata    = d;
        cyc();
        memwrite = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        memwrite = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        tx_ready = 1'b0;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rd(A_STATUS, 32'h0002_0000, "rst_status");
        cyc();
        cyc();
        reset = 1'b0;

        // Cycle counter reads n-1 before the n-th edge after release.
        rd(A_CYCLE, 32'd0, "cycle_0");
        cyc();
        rd(A_CYCLE, 32'd1, "cycle_1");
        cyc();
        cyc();
        cyc();
        rd(A_CYCLE, 32'd4, "cycle_4");

        // RAM store/load, byte-offset ignore, upper-bit alias.
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_10");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_13");
        rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
        wr(32'hFFFF_FF10, 32'h1234_5678);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "mmio_wr_no_ram");
        rd(32'hFFFF_FF10, 32'd0, "mmio_other_rd");

        // Counter wrap.
        force dut.cycle_d = 32'hFFFF_FFFF;
        cyc();
        release dut.cycle_d;
        rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_max");
        cyc();
        rd(A_CYCLE, 32'd0, "cycle_wrap");

        // Fill past capacity with the sink stalled.
        for (int i = 1; i <= 5; i++) wr(A_TXDATA, i);
        rd(A_STATUS, 32'h8001_0004, "status_full_ovf");
        rd(A_TXDATA, 32'd0, "txdata_rd");
        chk("full_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("full_head", tx_data, 32'd1);
        cyc();
        chk("stall_head", tx_data, 32'd1);
        tx_ready = 1'b1;
        #1;
        chk("drain_1", tx_data, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("drain_n", tx_data, i);
        end
        cyc();
        chk("drain_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        rd(A_STATUS, 32'h8002_0000, "status_empty_ovf");

        // Writing STATUS with bit31 clear leaves ovf; bit31 set clears it.
        wr(A_STATUS, 32'h7FFF_FFFF);
        rd(A_STATUS, 32'h8002_0000, "ovf_kept");
        wr(A_STATUS, 32'h8000_0000);
        rd(A_STATUS, 32'h0002_0000, "ovf_cleared");

        // Push and pop on the same edge while full.
        for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'hA0 + i);
        rd(A_STATUS, 32'h0001_0004, "refull");
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'hA4);
        tx_ready = 1'b0;
        rd(A_STATUS, 32'h0001_0004, "pushpop_full");
        chk("pushpop_head", tx_data, 32'hA1);
        tx_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("pushpop_drain", tx_data, 32'hA0 + i);
        end
        cyc();
        chk("pushpop_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Core loop: committed sw, branch, flushed sw bubble.
        for (int k = 0; k < 3; k++) begin
            wr(A_TXDATA, 32'h100 + k);
            memwrite = 1'b0;
            addr     = 32'h0000_0020;
            cyc();
            memwrite = 1'b0;
            addr     = A_TXDATA;
            wdata    = 32'h0000_0BAD;
            cyc();
        end
        rd(A_STATUS, 32'h0000_0003, "core_count");
        tx_ready = 1'b1;
        #1;
        chk("core_0", tx_data, 32'h100);
        cyc();
        chk("core_1", tx_data, 32'h101);
        cyc();
        chk("core_2", tx_data, 32'h102);
        cyc();
        chk("core_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Halt flag.
        rd(A_HALT, 32'd0, "halt_rd0");
        memwrite = 1'b1;
        addr     = A_HALT;
        wdata    = 32'd0;
        #1;
        chk("halt_before_edge", {31'd0, halted}, 32'd0);
        cyc();
        memwrite = 1'b0;
        chk("halt_set", {31'd0, halted}, 32'd1);
        rd(A_HALT, 32'd1, "halt_rd1");

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h200 + i);
        tx_ready = 1'b1;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        rd(A_STATUS, 32'h0002_0000, "mid_rst_status");
        rd(A_CYCLE, 32'd0, "mid_rst_cycle");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "mid_rst_ram");
        tx_ready = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        rd(A_CYCLE, 32'd1, "post_rst_cycle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
